// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage RV32I pipeline.
//
// Combines the hazard detector's stall request, the EX branch redirect and the
// instruction/data memory readiness into per-stage controls. Also keeps
// saturating stall/flush performance counters and a sticky watchdog flag that
// trips when a data hazard persists for MAX_STALL consecutive cycles.
//
// Ports:
//   clk, reset_n     pipeline clock (rising edge), async active-low reset
//   hazard_stall     data hazard present
//   branch_taken     EX resolved a taken branch/jump this cycle
//   imem_ready       instruction memory delivers a valid word this cycle
//   dmem_busy        MEM-stage data access not yet complete
//   pc_write_en      PC update enable
//   if_id_write_en   IF/ID load enable
//   if_id_flush      load NOP into IF/ID (meaningful with if_id_write_en)
//   id_ex_bubble     load control-zero into ID/EX
//   ex_mem_hold      hold EX/MEM and MEM/WB
//   state            FSM state: RUN=0, HAZ=1, MEM=2, FLUSH=3
//   stall_cycles     cycles with pc_write_en=0 (saturating)
//   flush_count      accepted branch redirects (saturating)
//   stall_timeout    sticky watchdog flag
module pipeline_ctrl #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned MAX_STALL = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hazard_stall,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_busy,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_hold,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             stall_timeout
);

  localparam int unsigned HazW = $clog2(MAX_STALL + 1);
  localparam logic [HazW-1:0] HazMax = HazW'(MAX_STALL);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StHaz   = 2'd1,
    StMem   = 2'd2,
    StFlush = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic [HazW-1:0]  haz_run_q, haz_run_d;
  logic             stall_timeout_q, stall_timeout_d;

  // Which decode case won this cycle; drives the counters.
  logic             redirect;
  logic             haz_win;

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StRun;
      stall_cycles_q  <= '0;
      flush_count_q   <= '0;
      haz_run_q       <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      stall_cycles_q  <= stall_cycles_d;
      flush_count_q   <= flush_count_d;
      haz_run_q       <= haz_run_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  // Next state. RUN/HAZ/MEM decode identically; they only record the cause.
  always_comb begin
    state_d = StRun;
    if (dmem_busy) begin
      state_d = (state_q == StFlush) ? StFlush : StMem;
    end else if (state_q == StFlush) begin
      state_d = StRun;
    end else if (branch_taken) begin
      state_d = StFlush;
    end else if (hazard_stall) begin
      state_d = StHaz;
    end else begin
      state_d = StRun;
    end
  end

  // Stage controls, zero-latency from state and inputs; all low in reset.
  always_comb begin
    pc_write_en    = 1'b0;
    if_id_write_en = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    ex_mem_hold    = 1'b0;
    redirect       = 1'b0;
    haz_win        = 1'b0;
    if (reset_n) begin
      if (dmem_busy) begin
        ex_mem_hold = 1'b1;
      end else if (state_q == StFlush) begin
        // Squash the wrong-path word that arrives one cycle after a redirect.
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b1;
        id_ex_bubble   = 1'b1;
        pc_write_en    = imem_ready;
      end else if (branch_taken) begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b1;
        id_ex_bubble   = 1'b1;
        redirect       = 1'b1;
      end else if (hazard_stall) begin
        id_ex_bubble = 1'b1;
        haz_win      = 1'b1;
      end else if (!imem_ready) begin
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b1;
      end else begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
      end
    end
  end

  // Saturating counters and watchdog.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_write_en && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    flush_count_d = flush_count_q;
    if (redirect && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
    haz_run_d = '0;
    if (haz_win) begin
      haz_run_d = (haz_run_q == HazMax) ? haz_run_q : haz_run_q + HazW'(1);
    end
    stall_timeout_d = stall_timeout_q | (haz_run_d == HazMax);
  end

  assign state         = state_q;
  assign stall_cycles  = stall_cycles_q;
  assign flush_count   = flush_count_q;
  assign stall_timeout = stall_timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl with CNT_W=4 and MAX_STALL=4 so that counter
// saturation and the watchdog are reachable in a short run.
module tb_pipeline_ctrl;

  localparam int unsigned CntW     = 4;
  localparam int unsigned MaxStall = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            hazard_stall, branch_taken, imem_ready, dmem_busy;
  logic            pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_mem_hold;
  logic [1:0]      state;
  logic [CntW-1:0] stall_cycles, flush_count;
  logic            stall_timeout;
  logic [4:0]      ctrl_w;

  pipeline_ctrl #(
    .CNT_W    (CntW),
    .MAX_STALL(MaxStall)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .hazard_stall  (hazard_stall),
    .branch_taken  (branch_taken),
    .imem_ready    (imem_ready),
    .dmem_busy     (dmem_busy),
    .pc_write_en   (pc_write_en),
    .if_id_write_en(if_id_write_en),
    .if_id_flush   (if_id_flush),
    .id_ex_bubble  (id_ex_bubble),
    .ex_mem_hold   (ex_mem_hold),
    .state         (state),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count),
    .stall_timeout (stall_timeout)
  );

  always #5 clk = ~clk;

  // {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_mem_hold}
  assign ctrl_w = {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_mem_hold};

  typedef struct {
    logic       hz;
    logic       br;
    logic       im;
    logic       db;
    logic [4:0] ctrl;  // expected stage controls this cycle
    logic [1:0] st;    // expected state after the edge
    logic [3:0] sc;    // expected stall_cycles after the edge
    logic [3:0] fc;    // expected flush_count after the edge
    logic       to;    // expected stall_timeout after the edge
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one vector, check controls mid-cycle, then registered state after the edge.
  task automatic apply(input vec_t v, input string name);
    vec_t e;
    hazard_stall = v.hz;
    branch_taken = v.br;
    imem_ready   = v.im;
    dmem_busy    = v.db;
    exp_q.push_back(v);
    #2;
    e = exp_q.pop_front();
    check({name, " ctrl"}, 32'(ctrl_w), 32'(e.ctrl));
    @(posedge clk);
    #1;
    check({name, " regs"}, 32'({state, stall_cycles, flush_count, stall_timeout}),
          32'({e.st, e.sc, e.fc, e.to}));
  endtask

  task automatic check_reset_zero(input string name);
    check({name, " ctrl"}, 32'(ctrl_w), 32'd0);
    check({name, " regs"}, 32'({state, stall_cycles, flush_count, stall_timeout}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset_n      = 1'b0;
    hazard_stall = 1'b0;
    branch_taken = 1'b0;
    imem_ready   = 1'b0;
    dmem_busy    = 1'b0;

    //                hz    br    im    db    ctrl      st  sc  fc  to
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 5'b11000, 2'd0, 4'd0, 4'd0, 1'b0}); // idle run
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 5'b00010, 2'd1, 4'd1, 4'd0, 1'b0}); // hazard x3
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 5'b00010, 2'd1, 4'd2, 4'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 5'b00010, 2'd1, 4'd3, 4'd0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 5'b11000, 2'd0, 4'd3, 4'd0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 5'b11110, 2'd3, 4'd3, 4'd1, 1'b0}); // redirect
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 5'b11110, 2'd0, 4'd3, 4'd1, 1'b0}); // FLUSH ignores hz
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 5'b11000, 2'd0, 4'd3, 4'd1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 5'b00001, 2'd2, 4'd4, 4'd1, 1'b0}); // busy beats br
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 5'b00001, 2'd2, 4'd5, 4'd1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 5'b11110, 2'd3, 4'd5, 4'd2, 1'b0}); // redirect
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 5'b00001, 2'd3, 4'd6, 4'd2, 1'b0}); // FLUSH held
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 5'b01110, 2'd0, 4'd7, 4'd2, 1'b0}); // FLUSH, no imem
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 5'b01100, 2'd0, 4'd8, 4'd2, 1'b0}); // fetch wait
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 5'b00010, 2'd1, 4'd9, 4'd2, 1'b0}); // hazard x4
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 5'b00010, 2'd1, 4'd10, 4'd2, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 5'b00010, 2'd1, 4'd11, 4'd2, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 5'b00010, 2'd1, 4'd12, 4'd2, 1'b1}); // watchdog
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 5'b11000, 2'd0, 4'd12, 4'd2, 1'b1}); // sticky
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 5'b00010, 2'd1, 4'd13, 4'd2, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 5'b00010, 2'd1, 4'd14, 4'd2, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 5'b00010, 2'd1, 4'd15, 4'd2, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 5'b00010, 2'd1, 4'd15, 4'd2, 1'b1}); // saturated
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 5'b00010, 2'd1, 4'd15, 4'd2, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 5'b11000, 2'd0, 4'd15, 4'd2, 1'b1});

    // Reset state with controls forced low.
    #2;
    check_reset_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset mid-stall: everything zero at once, including the sticky flag.
    apply('{1'b1, 1'b0, 1'b1, 1'b0, 5'b00010, 2'd1, 4'd15, 4'd2, 1'b1}, "pre_rst_haz");
    reset_n = 1'b0;
    #1;
    check_reset_zero("rst_mid_stall");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    apply('{1'b0, 1'b0, 1'b1, 1'b0, 5'b11000, 2'd0, 4'd0, 4'd0, 1'b0}, "post_rst_run");

    // Reset mid-FLUSH: the first cycle after release decodes from RUN.
    apply('{1'b0, 1'b1, 1'b1, 1'b0, 5'b11110, 2'd3, 4'd0, 4'd1, 1'b0}, "pre_rst_br");
    reset_n = 1'b0;
    #1;
    check_reset_zero("rst_mid_flush");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    apply('{1'b1, 1'b0, 1'b1, 1'b0, 5'b00010, 2'd1, 4'd1, 4'd0, 1'b0}, "post_rst_haz");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
